// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet input loader: data width, the quiet-NaN
// timeout marker and the loader FSM state encoding.
package maxnet_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_OUT   = 3'd4
  } state_e;

endpackage

// File: rtl/fp_sanitize.sv
// Clamps one IEEE-754 single to the non-negative domain MaxNet expects:
// anything with the sign bit set (including -0) and any NaN becomes +0.
// +Inf, denormals and ordinary positives pass through unchanged.
module fp_sanitize
  import maxnet_pkg::*;
(
  input  logic [DATA_W-1:0] in_word,
  output logic [DATA_W-1:0] out_word
);

  logic is_neg;
  logic is_nan;

  // Classify from the raw fields; no arithmetic needed.
  always_comb begin
    is_neg   = in_word[31];
    is_nan   = (in_word[30:23] == 8'hFF) && (in_word[22:0] != 23'd0);
    out_word = (is_neg || is_nan) ? '0 : in_word;
  end

endmodule

// File: rtl/maxnet_input_loader.sv
// Collects four sanitized words, kicks the MaxNet controller, waits for done
// (or a timeout) and presents one result through a valid/ready handshake.
module maxnet_input_loader
  import maxnet_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] inp1,
  output logic [DATA_W-1:0] inp2,
  output logic [DATA_W-1:0] inp3,
  output logic [DATA_W-1:0] inp4,
  output logic              start,
  input  logic              done,
  input  logic [DATA_W-1:0] max,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0][DATA_W-1:0]  inp_q, inp_d;
  logic                    start_q, start_d;
  logic                    res_valid_q, res_valid_d;
  logic [DATA_W-1:0]       res_data_q, res_data_d;
  logic                    res_err_q, res_err_d;
  logic                    busy_q, busy_d;
  logic [DATA_W-1:0]       san_word;
  logic                    xfer;

  fp_sanitize u_san (
    .in_word  (in_data),
    .out_word (san_word)
  );

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_FILL);
  assign xfer      = in_valid && in_ready;
  assign inp1      = inp_q[0];
  assign inp2      = inp_q[1];
  assign inp3      = inp_q[2];
  assign inp4      = inp_q[3];
  assign start     = start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

  // Next-state and datapath updates; outputs are derived from the next state
  // so they leave the flops aligned with the state they describe.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    inp_d      = inp_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    unique case (state_q)
      S_IDLE, S_FILL: begin
        if (xfer) begin
          inp_d[idx_q] = san_word;
          idx_d        = idx_q + 2'd1;
          state_d      = S_FILL;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            // Slots 0..2 were all rewritten during this fill, so they are fresh.
            if ((inp_q[0] | inp_q[1] | inp_q[2] | san_word) == '0) begin
              state_d    = S_OUT;
              res_data_d = '0;
              res_err_d  = 1'b0;
            end else begin
              state_d = S_START;
            end
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // done has priority over an expiring timeout in the same cycle
        if (done) begin
          res_data_d = max;
          res_err_d  = 1'b0;
          state_d    = S_OUT;
        end else if (cnt_q == TO_MAX) begin
          res_data_d = QNAN;
          res_err_d  = 1'b1;
          state_d    = S_OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    start_d     = (state_d == S_START);
    res_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any partial fill or run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      inp_q       <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      inp_q       <= inp_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Bench for maxnet_input_loader: directed table of sets, reset corner cases,
// then randomized sets checked against a transaction-level model.
module tb_maxnet_input_loader;

  localparam int TO = 15;
  localparam logic [31:0] QNAN_C = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, done, res_ready;
  logic [31:0] in_data, max;
  logic [31:0] inp1, inp2, inp3, inp4, res_data;
  logic        start, res_valid, res_err, busy;
  logic [3:0][31:0] inp_all;

  int vectors = 0;
  int miscompares = 0;

  assign inp_all = {inp4, inp3, inp2, inp1};

  maxnet_input_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inp1(inp1), .inp2(inp2), .inp3(inp3), .inp4(inp4),
    .start(start), .done(done), .max(max), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0][31:0] w;
    logic [3:0][31:0] exp_inp;
    bit               exp_start;
    int               dly;
    logic [31:0]      maxv;
    logic [31:0]      exp_res;
    bit               exp_err;
    int               stall;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][31:0] mk(input logic [31:0] a, b, c, d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Model of the value rule: negatives (incl. -0) and NaNs become +0.
  function automatic logic [31:0] ref_san(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    if (w[31] == 1'b1) return 32'h0;
    if (e == 8'hFF && m != 23'd0) return 32'h0;
    return w;
  endfunction

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int budget;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        done = 1'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    budget   = 0;
    while (!in_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (budget == 20) chk("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic do_set(input string tag, input logic [3:0][31:0] w,
                        input logic [3:0][31:0] exp_inp, input bit exp_start,
                        input int dly, input logic [31:0] maxv,
                        input logic [31:0] exp_res, input bit exp_err,
                        input int stall, input bit gaps);
    int n;
    int exp_len;
    for (int k = 0; k < 4; k++) send_word(w[k], gaps);
    done = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s.inp%0d", tag, k + 1), inp_all[k], exp_inp[k]);
    chk({tag, ".start"}, 32'(start), 32'(exp_start));
    if (exp_start) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      done = 1'($urandom);  // ignored while in START
      tick();
      chk({tag, ".start_drop"}, 32'(start), 32'd0);
      exp_len = (dly <= TO) ? dly + 1 : TO + 1;
      n = 0;
      while (!res_valid && n < 100) begin
        done = (n >= dly);
        max  = maxv;
        tick();
        n++;
      end
      done = 1'b0;
      chk({tag, ".run_len"}, 32'(n), 32'(exp_len));
    end
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".res_data"}, res_data, exp_res);
    chk({tag, ".res_err"}, 32'(res_err), 32'(exp_err));
    res_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      done = 1'($urandom);
      in_valid = 1'($urandom);
      tick();
      chk({tag, ".stall_valid"}, 32'(res_valid), 32'd1);
      chk({tag, ".stall_data"}, res_data, exp_res);
      chk({tag, ".stall_inp"}, inp_all[s % 4], exp_inp[s % 4]);
      chk({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    done = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".post_busy"}, 32'(busy), 32'd0);
    chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".inp1"}, inp1, 32'h0);
    chk({tag, ".inp2"}, inp2, 32'h0);
    chk({tag, ".inp3"}, inp3, 32'h0);
    chk({tag, ".inp4"}, inp4, 32'h0);
    chk({tag, ".start"}, 32'(start), 32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".res_data"}, res_data, 32'h0);
    chk({tag, ".res_err"}, 32'(res_err), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] rand_word(input bit neg_only);
    logic [31:0] r;
    r = $urandom;
    if (neg_only) begin
      case ($urandom_range(0, 2))
        0: return {1'b1, r[30:0]};
        1: return 32'h8000_0000;
        default: return 32'h0;
      endcase
    end
    case ($urandom_range(0, 6))
      0: return r;
      1: return {1'b0, r[30:0]};
      2: return 32'h8000_0000;
      3: return {1'b0, 8'hFF, r[22:1], 1'b1};
      4: return 32'h7F80_0000;
      5: return 32'h0;
      default: return {1'b0, r[30:23] & 8'hFE, r[22:0]};
    endcase
  endfunction

  vec_t tbl[6];

  initial begin
    tbl[0] = '{mk(32'h40400000, 32'h40E00000, 32'h40A00000, 32'h3F800000),
               mk(32'h40400000, 32'h40E00000, 32'h40A00000, 32'h3F800000),
               1'b1, 3, 32'h40E00000, 32'h40E00000, 1'b0, 0};
    tbl[1] = '{mk(32'hC0000000, 32'h7FC00001, 32'h40800000, 32'h3F800000),
               mk(32'h0, 32'h0, 32'h40800000, 32'h3F800000),
               1'b1, 0, 32'h40800000, 32'h40800000, 1'b0, 1};
    tbl[2] = '{mk(32'hBF800000, 32'h80000000, 32'h00000000, 32'hC0400000),
               mk(32'h0, 32'h0, 32'h0, 32'h0),
               1'b0, 0, 32'h12345678, 32'h0, 1'b0, 2};
    tbl[3] = '{mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
               mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
               1'b1, 1000, 32'h40800000, QNAN_C, 1'b1, 10};
    tbl[4] = '{mk(32'h7F800000, 32'h7F800001, 32'hFF800000, 32'h00000001),
               mk(32'h7F800000, 32'h0, 32'h0, 32'h00000001),
               1'b1, 15, 32'h11111111, 32'h11111111, 1'b0, 0};
    tbl[5] = '{mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h3F000000),
               mk(32'h0, 32'h0, 32'h0, 32'h3F000000),
               1'b1, 16, 32'h3F000000, QNAN_C, 1'b1, 3};

    rst = 1'b0; in_valid = 1'b0; in_data = '0; done = 1'b0;
    max = '0; res_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    #11;
    rst = 1'b1;
    tick();
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    foreach (tbl[i])
      do_set($sformatf("tbl%0d", i), tbl[i].w, tbl[i].exp_inp, tbl[i].exp_start,
             tbl[i].dly, tbl[i].maxv, tbl[i].exp_res, tbl[i].exp_err,
             tbl[i].stall, 1'b0);

    // Reset after two transfers: outputs clear at once, next four form a new set.
    send_word(32'h40400000, 1'b0);
    send_word(32'h40E00000, 1'b0);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_fill");
    #1 rst = 1'b1;
    tick();
    do_set("rst_fresh", mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
           mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
           1'b1, 2, 32'h40800000, 32'h40800000, 1'b0, 0, 1'b0);

    // Reset while running: no result may appear afterwards.
    for (int k = 0; k < 4; k++) send_word(32'h40000000, 1'b0);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_run");
    #1 rst = 1'b1;
    done = 1'b1;
    repeat (20) tick();
    done = 1'b0;
    chk("rst_run.no_result", 32'(res_valid), 32'd0);
    chk("rst_run.idle", 32'(busy), 32'd0);

    // Randomized sets against the transaction model.
    for (int i = 0; i < 24; i++) begin
      logic [3:0][31:0] w, ei;
      bit es, ee, neg_only;
      int d;
      logic [31:0] mv, er;
      neg_only = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 4; k++) begin
        w[k]  = rand_word(neg_only);
        ei[k] = ref_san(w[k]);
      end
      es = (ei != '0);
      d  = $urandom_range(0, 20);
      mv = $urandom;
      er = !es ? 32'h0 : (d <= TO ? mv : QNAN_C);
      ee = es && (d > TO);
      do_set($sformatf("rnd%0d", i), w, ei, es, d, mv, er, ee,
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
